alu_req_arbiter: RTL and testbench
==================================

Name: alu_req_arbiter

Overview:
- Shares one ALU (sequenced by the existing ALU control FSM) between N_REQ independent requesters.
- Arbitrates round-robin, latches one operation, and pulses the ALU start.
- Waits for the ALU done, with a watchdog timeout, then returns the result tagged with the requester ID.
- Sits between client blocks and the ALU start/opcode/done interface.

Parameters:
- N_REQ, 4, number of requesters.
- ID_W, 2, requester ID width; must equal clog2(N_REQ).
- DATA_W, 8, operand width.
- RES_W, 16, result width (holds the full MUL product).
- TIMEOUT, 64, maximum WAIT cycles before an op is aborted; must be at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  N_REQ  per-requester operation request.
- req_opcode  in  3*N_REQ  flattened opcodes; requester i uses bits [3i+2:3i].
- req_a  in  DATA_W*N_REQ  flattened operand A.
- req_b  in  DATA_W*N_REQ  flattened operand B.
- req_ready  out  N_REQ  one-hot accept, combinational.
- alu_start  out  1  one-cycle start pulse to the ALU controller.
- alu_opcode  out  3  latched opcode.
- alu_a  out  DATA_W  latched operand A.
- alu_b  out  DATA_W  latched operand B.
- alu_done  in  1  ALU completion pulse.
- alu_result  in  RES_W  ALU result, valid with alu_done.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  ID_W  requester index of the response.
- rsp_result  out  RES_W  result; 0 on error.
- rsp_err  out  1  1 = timeout or illegal opcode.
- busy  out  1  high when state != IDLE.
- stat_timeouts  out  8  saturating count of timeouts.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, rr_ptr=0.
  - All registered outputs = 0: alu_start, alu_opcode, alu_a, alu_b, rsp_*, stat_timeouts.
  - req_ready=0 and busy=0.
  - Any in-flight op is discarded; no response is ever issued for it.
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - grant = first i with req_valid[i]=1, searching from rr_ptr upward with wrap-around.
  - req_ready[grant]=1 only in this state, only for that index; the handshake completes in the same cycle.
  - On handshake, latch opcode, a, b and id.
  - Next state is ISSUE if opcode != 3'b111, else RESPOND with err=1 and result=0.
  - With no valid request, stay in IDLE.
- ISSUE:
  - alu_start=1 for exactly this cycle.
  - alu_opcode, alu_a and alu_b are held stable from ISSUE through the end of WAIT.
  - Clear timer; go to WAIT.
  - alu_done is ignored in ISSUE.
- WAIT:
  - timer = number of prior WAIT cycles for this op (0, 1, 2, ...).
  - If alu_done=1: capture alu_result, err=0, go to RESPOND.
  - Else if timer==TIMEOUT-1: result=0, err=1, stat_timeouts += 1 (saturating at 255), go to RESPOND.
  - Else timer += 1.
  - If alu_done and timeout coincide, done wins.
- RESPOND:
  - rsp_valid=1 for one cycle, with rsp_id, rsp_result and rsp_err stable.
  - rr_ptr = (id + 1) mod N_REQ.
  - Next state is IDLE; no new accept occurs in this cycle.
  - rsp_id, rsp_result and rsp_err hold their values until the next response.
- Latency:
  - Accept at cycle T gives alu_start at T+1.
  - alu_done seen in cycle D gives rsp_valid at D+1.
  - An illegal opcode gives rsp_valid at T+1.
  - Timeout gives rsp_valid at T+TIMEOUT+2.
  - Minimum spacing between accepts is 4 cycles, or 2 for an illegal opcode.
- Requesters may drop req_valid without a handshake; no state is kept for them.
- Requests that arrive during busy wait until the FSM returns to IDLE.
- Spurious alu_done in IDLE or RESPOND is ignored.

Test Plan:
1. Single op: req0 ADD (000), a=5, b=3; ALU model asserts done with result 8 three cycles after start.
   -> req_ready[0] at T, alu_start at T+1 only, rsp_valid at T+5 with id=0, result=8, err=0.
2. Round-robin fairness: after reset, req_valid=4'b1111 held.
   -> grant order 0,1,2,3,0.
   Then req_valid=4'b0101 held -> order alternates 2,0,2,0.
3. Illegal opcode: req1 opcode 3'b111, a=9, b=9.
   -> alu_start never asserted; rsp_valid at T+1 with id=1, result=0, err=1; stat_timeouts stays 0.
4. Timeout: ALU model never asserts done, TIMEOUT=64.
   -> rsp_valid at T+66 with err=1, result=0; stat_timeouts=1.
   Repeat 256 times -> stat_timeouts saturates at 255.
5. Coincident done and timeout: alu_done asserted in the WAIT cycle where timer=63, with alu_result=16'h00C8.
   -> rsp_err=0, rsp_result=16'h00C8; stat_timeouts unchanged.
6. Reset mid-op: drive reset=0 during WAIT.
   -> busy=0 and all outputs 0 immediately (asynchronous); no rsp_valid after release.
   Then req_valid=4'b1100 -> req2 is granted first (rr_ptr=0).

Source files
------------

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU between N_REQ requesters.
// Latches one op, pulses alu_start, waits for alu_done under a watchdog, returns a tagged result.
module alu_req_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 8,
  parameter int RES_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [3*N_REQ-1:0]        req_opcode,
  input  logic [DATA_W*N_REQ-1:0]   req_a,
  input  logic [DATA_W*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      alu_start,
  output logic [2:0]                alu_opcode,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic                      alu_done,
  input  logic [RES_W-1:0]          alu_result,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [RES_W-1:0]          rsp_result,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [7:0]                stat_timeouts
);

  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ID_W-1:0]     rr_ptr_r;
  logic [ID_W-1:0]     id_r;
  logic [ID_W-1:0]     grant_s;
  logic                found_s;
  logic                accept_s;
  logic                illegal_s;
  logic                timeout_s;
  logic [2:0]          sel_opcode_s;
  logic [DATA_W-1:0]   sel_a_s;
  logic [DATA_W-1:0]   sel_b_s;
  logic [TMR_W-1:0]    timer_r;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (id == ID_W'(N_REQ - 1)) begin
      return '0;
    end else begin
      return id + ID_W'(1);
    end
  endfunction

  // Round-robin search from rr_ptr with wrap, then mux out the granted request fields
  always_comb begin
    grant_s      = '0;
    found_s      = 1'b0;
    sel_opcode_s = 3'b000;
    sel_a_s      = '0;
    sel_b_s      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found_s && req_valid[(int'(rr_ptr_r) + k) % N_REQ]) begin
        found_s = 1'b1;
        grant_s = ID_W'((int'(rr_ptr_r) + k) % N_REQ);
      end else begin
        grant_s = grant_s;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_s == ID_W'(i)) begin
        sel_opcode_s = req_opcode[3*i +: 3];
        sel_a_s      = req_a[DATA_W*i +: DATA_W];
        sel_b_s      = req_b[DATA_W*i +: DATA_W];
      end else begin
        sel_opcode_s = sel_opcode_s;
      end
    end
  end

  // reset is folded in so no handshake can be seen while the block is held in reset
  assign accept_s  = (state_r == ST_IDLE) && found_s && reset;
  assign illegal_s = (sel_opcode_s == OP_ILLEGAL);
  assign timeout_s = (timer_r == TMR_LAST);
  assign req_ready = accept_s ? (N_REQ'(1) << grant_s) : '0;
  assign busy      = (state_r != ST_IDLE);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; done takes priority over the watchdog in WAIT
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = illegal_s ? ST_RESPOND : ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (alu_done || timeout_s) begin
          state_nxt_s = ST_RESPOND;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESPOND: state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // Operation latch, watchdog timer, response and statistics registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_r      <= '0;
      id_r          <= '0;
      timer_r       <= '0;
      alu_start     <= 1'b0;
      alu_opcode    <= 3'b000;
      alu_a         <= '0;
      alu_b         <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_result    <= '0;
      rsp_err       <= 1'b0;
      stat_timeouts <= 8'd0;
    end else begin
      alu_start <= 1'b0;
      rsp_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            id_r <= grant_s;
            if (illegal_s) begin
              rsp_valid  <= 1'b1;
              rsp_id     <= grant_s;
              rsp_result <= '0;
              rsp_err    <= 1'b1;
            end else begin
              alu_start  <= 1'b1;
              alu_opcode <= sel_opcode_s;
              alu_a      <= sel_a_s;
              alu_b      <= sel_b_s;
            end
          end
        end
        ST_ISSUE: timer_r <= '0;
        ST_WAIT: begin
          if (alu_done) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= id_r;
            rsp_result <= alu_result;
            rsp_err    <= 1'b0;
          end else if (timeout_s) begin
            rsp_valid     <= 1'b1;
            rsp_id        <= id_r;
            rsp_result    <= '0;
            rsp_err       <= 1'b1;
            stat_timeouts <= sat_inc8(stat_timeouts);
          end else begin
            timer_r <= timer_r + TMR_W'(1);
          end
        end
        ST_RESPOND: rr_ptr_r <= next_id(id_r);
        default: rr_ptr_r <= rr_ptr_r;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: directed scenarios plus randomized traffic,
// checked cycle by cycle against a transaction-level model of grant order, latency and counters.
module tb_alu_req_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int DW = 8;
  localparam int RW = 16;
  localparam int TO = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [3*N-1:0]   req_opcode;
  logic [DW*N-1:0]  req_a;
  logic [DW*N-1:0]  req_b;
  logic [N-1:0]     req_ready;
  logic             alu_start;
  logic [2:0]       alu_opcode;
  logic [DW-1:0]    alu_a;
  logic [DW-1:0]    alu_b;
  logic             alu_done;
  logic [RW-1:0]    alu_result;
  logic             rsp_valid;
  logic [IW-1:0]    rsp_id;
  logic [RW-1:0]    rsp_result;
  logic             rsp_err;
  logic             busy;
  logic [7:0]       stat_timeouts;

  alu_req_arbiter #(.N_REQ(N), .ID_W(IW), .DATA_W(DW), .RES_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .alu_start(alu_start), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .busy(busy), .stat_timeouts(stat_timeouts)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int m_rr   = 0;
  int m_stat = 0;
  int g;
  logic [2:0]    op_v [N];
  logic [DW-1:0] a_v  [N];
  logic [DW-1:0] b_v  [N];
  int exp_a [5] = '{0, 1, 2, 3, 0};
  int exp_b [4] = '{2, 0, 2, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic drive_req(input logic [N-1:0] m);
    req_valid = m;
    for (int i = 0; i < N; i++) begin
      req_opcode[3*i +: 3] = op_v[i];
      req_a[DW*i +: DW]    = a_v[i];
      req_b[DW*i +: DW]    = b_v[i];
    end
  endtask

  task automatic randomize_reqs();
    for (int i = 0; i < N; i++) begin
      op_v[i] = ($urandom_range(0, 7) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
      a_v[i]  = DW'($urandom);
      b_v[i]  = DW'($urandom);
    end
  endtask

  // One arbitrated op. d = cycles from alu_start to alu_done (1..TO), or -1 for no done.
  task automatic txn(input logic [N-1:0] m, input int d, input logic [RW-1:0] res, output int gr);
    int rk;
    logic legal;
    logic [RW-1:0] er;
    logic ee;
    logic spur;
    @(negedge clk);
    drive_req(m);
    alu_done   = 1'($urandom_range(0, 1));
    alu_result = RW'($urandom);
    #1;
    gr = pick(m, m_rr);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("grant", 32'(req_ready), 32'(1) << gr);
    legal = (op_v[gr] != 3'b111);
    rk    = !legal ? 1 : ((d >= 0) ? d + 2 : TO + 2);
    er    = (legal && d >= 0) ? res : '0;
    ee    = !(legal && d >= 0);
    spur  = 1'($urandom_range(0, 1));
    for (int k = 1; k <= rk; k++) begin
      @(negedge clk);
      alu_done   = (legal && d >= 0 && k == d + 1) || (k == 1 && spur) || (k == rk && spur);
      alu_result = (legal && d >= 0 && k == d + 1) ? res : RW'($urandom);
      #1;
      chk("alu_start", 32'(alu_start), 32'(legal && k == 1));
      chk("rsp_valid", 32'(rsp_valid), 32'(k == rk));
      chk("ready_busy", 32'(req_ready), 32'd0);
      chk("busy", 32'(busy), 32'd1);
      if (legal && k < rk) begin
        chk("alu_opcode", 32'(alu_opcode), 32'(op_v[gr]));
        chk("alu_a", 32'(alu_a), 32'(a_v[gr]));
        chk("alu_b", 32'(alu_b), 32'(b_v[gr]));
      end
    end
    m_rr = (gr + 1) % N;
    if (legal && d < 0) m_stat = (m_stat < 255) ? m_stat + 1 : 255;
    chk("rsp_id", 32'(rsp_id), 32'(gr));
    chk("rsp_result", 32'(rsp_result), 32'(er));
    chk("rsp_err", 32'(rsp_err), 32'(ee));
    chk("stat_timeouts", 32'(stat_timeouts), 32'(m_stat));
    alu_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_start"}, 32'(alu_start), 32'd0);
    chk({tag, "_op"}, 32'({alu_opcode, alu_a, alu_b}), 32'd0);
    chk({tag, "_rsp"}, 32'({rsp_valid, rsp_id, rsp_err}), 32'd0);
    chk({tag, "_result"}, 32'(rsp_result), 32'd0);
    chk({tag, "_stat"}, 32'(stat_timeouts), 32'd0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) op_v[i] = 3'b000;
    drive_req('1);
    alu_done   = 1'b0;
    alu_result = '0;
    reset      = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset     = 1'b1;
    req_valid = '0;
    m_rr      = 0;
    m_stat    = 0;
  endtask

  initial begin
    do_reset();

    // Single ADD from requester 0
    randomize_reqs();
    op_v[0] = 3'b000; a_v[0] = 8'd5; b_v[0] = 8'd3;
    txn(4'b0001, 3, 16'd8, g);

    // Fairness with all requesters held, then two alternating
    do_reset();
    randomize_reqs();
    for (int i = 0; i < N; i++) op_v[i] = 3'($urandom_range(0, 6));
    for (int i = 0; i < 5; i++) begin
      txn(4'b1111, $urandom_range(1, 5), RW'($urandom), g);
      chk("rr_all", 32'(g), 32'(exp_a[i]));
    end
    for (int i = 0; i < 4; i++) begin
      txn(4'b0101, $urandom_range(1, 5), RW'($urandom), g);
      chk("rr_0101", 32'(g), 32'(exp_b[i]));
    end

    // Illegal opcode from requester 1
    op_v[1] = 3'b111; a_v[1] = 8'd9; b_v[1] = 8'd9;
    txn(4'b0010, 3, 16'h1234, g);
    chk("illegal_stat", 32'(stat_timeouts), 32'd0);

    // Done coinciding with the last watchdog cycle
    op_v[3] = 3'b010;
    txn(4'b1000, TO, 16'h00C8, g);
    chk("coincide_err", 32'(rsp_err), 32'd0);
    chk("coincide_res", 32'(rsp_result), 32'h00C8);

    // Randomized mixed traffic
    for (int n = 0; n < 40; n++) begin
      int r;
      int d;
      randomize_reqs();
      r = $urandom_range(0, 9);
      d = (r == 0) ? -1 : ((r < 3) ? $urandom_range(60, TO) : $urandom_range(1, 8));
      txn(N'($urandom_range(1, 15)), d, RW'($urandom), g);
    end

    // Timeouts until the counter saturates
    do_reset();
    for (int i = 0; i < N; i++) op_v[i] = 3'b100;
    for (int n = 0; n < 256; n++) begin
      txn(N'($urandom_range(1, 15)), -1, 16'h0, g);
    end
    chk("stat_sat", 32'(stat_timeouts), 32'd255);

    // Reset while an op is in WAIT
    @(negedge clk);
    op_v[1] = 3'b001;
    drive_req(4'b0010);
    #1;
    chk("pre_reset_grant", 32'(req_ready), 32'(1) << pick(4'b0010, m_rr));
    repeat (4) begin
      @(negedge clk);
      req_valid = '0;
    end
    req_valid = 4'b1111;
    reset     = 1'b0;
    #1;
    check_all_zero("mid_reset");
    m_rr   = 0;
    m_stat = 0;
    @(negedge clk);
    reset     = 1'b1;
    req_valid = '0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      alu_done   = 1'($urandom_range(0, 1));
      alu_result = RW'($urandom);
      #1;
      chk("post_reset_rsp", 32'(rsp_valid), 32'd0);
    end
    alu_done = 1'b0;
    for (int i = 0; i < N; i++) op_v[i] = 3'b000;
    txn(4'b1100, 2, 16'h0055, g);
    chk("post_reset_grant", 32'(g), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
